// File: rtl/bank_row_tracker_if.sv
// Request/command/result bundle between mapper, command FSM and bank_row_tracker.
// Latency: none (wires only). Backpressure: none; lookups and commands are fire-and-forget.
// Optional stats outputs exist only when BANK_ROW_TRACKER_STATS_EN is defined.
interface bank_row_tracker_if #(
  parameter int BANK_GROUP_BITS = 2,
  parameter int BANK_BITS       = 2,
  parameter int ROW_BITS        = 16
);
  localparam int NUM_BANKS = 2 ** (BANK_GROUP_BITS + BANK_BITS);

  logic                       lookup_valid;
  logic [BANK_GROUP_BITS-1:0] lookup_bg;
  logic [BANK_BITS-1:0]       lookup_bank;
  logic [ROW_BITS-1:0]        lookup_row;
  logic                       lookup_done;
  logic                       lookup_hit;
  logic                       lookup_miss;
  logic                       lookup_conflict;
  logic                       lookup_pre_ok;
  logic                       cmd_valid;
  logic [1:0]                 cmd_type;
  logic [BANK_GROUP_BITS-1:0] cmd_bg;
  logic [BANK_BITS-1:0]       cmd_bank;
  logic [ROW_BITS-1:0]        cmd_row;
  logic [NUM_BANKS-1:0]       open_mask;
  logic                       proto_err;
`ifdef BANK_ROW_TRACKER_STATS_EN
  logic [31:0]                stat_hits;
  logic [31:0]                stat_misses;
  logic [31:0]                stat_conflicts;
`endif

  // Driver side: mapper / command FSM
  modport master (
    output lookup_valid, lookup_bg, lookup_bank, lookup_row,
    output cmd_valid, cmd_type, cmd_bg, cmd_bank, cmd_row,
    input  lookup_done, lookup_hit, lookup_miss, lookup_conflict, lookup_pre_ok,
`ifdef BANK_ROW_TRACKER_STATS_EN
    input  stat_hits, stat_misses, stat_conflicts,
`endif
    input  open_mask, proto_err
  );

  // Tracker side
  modport slave (
    input  lookup_valid, lookup_bg, lookup_bank, lookup_row,
    input  cmd_valid, cmd_type, cmd_bg, cmd_bank, cmd_row,
    output lookup_done, lookup_hit, lookup_miss, lookup_conflict, lookup_pre_ok,
`ifdef BANK_ROW_TRACKER_STATS_EN
    output stat_hits, stat_misses, stat_conflicts,
`endif
    output open_mask, proto_err
  );
endinterface

// File: rtl/bank_row_tracker.sv
// Per-bank open-row/tRAS tracker: classifies lookups as hit/miss/conflict and checks PRE legality.
// Latency: lookup result 1 cycle after lookup_valid, fully pipelined; commands take effect next cycle.
// Backpressure: none; one lookup and one command accepted every cycle. Optional stats: BANK_ROW_TRACKER_STATS_EN.
module bank_row_tracker #(
  parameter int BANK_GROUP_BITS = 2,
  parameter int BANK_BITS       = 2,
  parameter int ROW_BITS        = 16,
  parameter int T_RAS           = 32
) (
  input  logic                CLK,
  input  logic                nRST,
  bank_row_tracker_if.slave   bus
);
  localparam int IDX_BITS  = BANK_GROUP_BITS + BANK_BITS;
  localparam int NUM_BANKS = 2 ** IDX_BITS;
  localparam int CNT_BITS  = $clog2(T_RAS + 1);
  localparam logic [CNT_BITS-1:0] TRAS_LD = CNT_BITS'(T_RAS);
  localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);
  localparam logic [1:0] CMD_ACT  = 2'b00;
  localparam logic [1:0] CMD_PRE  = 2'b01;
  localparam logic [1:0] CMD_PREA = 2'b10;

  // Bank table
  logic [NUM_BANKS-1:0] r_open;
  logic [ROW_BITS-1:0]  r_row [NUM_BANKS];
  logic [CNT_BITS-1:0]  r_cnt [NUM_BANKS];

  // Lookup result pipeline stage and sticky error
  logic r_done, r_hit, r_miss, r_conflict, r_pre_ok;
  logic r_err;

  logic [IDX_BITS-1:0]  w_lk_idx;
  logic [IDX_BITS-1:0]  w_cmd_idx;
  logic                 w_is_act, w_is_pre, w_is_prea;
  logic                 w_lk_open, w_lk_same, w_lk_cnt_zero;
  logic                 w_cmd_open, w_cmd_cnt_busy;
  logic                 w_prea_early;
  logic [NUM_BANKS-1:0] w_open_nxt;

  assign w_lk_idx  = {bus.lookup_bg, bus.lookup_bank};
  assign w_cmd_idx = {bus.cmd_bg, bus.cmd_bank};

  assign w_is_act  = bus.cmd_valid && (bus.cmd_type == CMD_ACT);
  assign w_is_pre  = bus.cmd_valid && (bus.cmd_type == CMD_PRE);
  assign w_is_prea = bus.cmd_valid && (bus.cmd_type == CMD_PREA);

  // Lookups see only the registered table, never this cycle's command
  assign w_lk_open     = r_open[w_lk_idx];
  assign w_lk_same     = (r_row[w_lk_idx] == bus.lookup_row);
  assign w_lk_cnt_zero = (r_cnt[w_lk_idx] == '0);

  assign w_cmd_open     = r_open[w_cmd_idx];
  assign w_cmd_cnt_busy = (r_cnt[w_cmd_idx] != '0);

  // PREA is early if any currently open bank is still inside its tRAS window
  always_comb begin
    w_prea_early = 1'b0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (r_open[i] && (r_cnt[i] != '0)) w_prea_early = 1'b1;
    end
  end

  // Next open bits: ACT sets, PRE clears even when early, PREA clears all
  always_comb begin
    w_open_nxt = r_open;
    if (w_is_act)  w_open_nxt[w_cmd_idx] = 1'b1;
    if (w_is_pre)  w_open_nxt[w_cmd_idx] = 1'b0;
    if (w_is_prea) w_open_nxt = '0;
  end

  // Open bits and sticky protocol-violation flag
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_open <= '0;
      r_err  <= 1'b0;
    end else begin
      r_open <= w_open_nxt;
      if ((w_is_act && w_cmd_open) ||
          (w_is_pre && w_cmd_open && w_cmd_cnt_busy) ||
          (w_is_prea && w_prea_early))
        r_err <= 1'b1;
    end
  end

  // Row registers and tRAS countdowns; ACT load wins over the decrement
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        r_row[i] <= '0;
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        if (w_is_act && (w_cmd_idx == IDX_BITS'(i))) begin
          r_row[i] <= bus.cmd_row;
          r_cnt[i] <= TRAS_LD;
        end else if (r_cnt[i] != '0) begin
          r_cnt[i] <= r_cnt[i] - CNT_ONE;
        end
      end
    end
  end

  // One-cycle lookup classification; all result bits low when no lookup
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_done     <= 1'b0;
      r_hit      <= 1'b0;
      r_miss     <= 1'b0;
      r_conflict <= 1'b0;
      r_pre_ok   <= 1'b0;
    end else begin
      r_done     <= bus.lookup_valid;
      r_hit      <= bus.lookup_valid && w_lk_open && w_lk_same;
      r_miss     <= bus.lookup_valid && !w_lk_open;
      r_conflict <= bus.lookup_valid && w_lk_open && !w_lk_same;
      r_pre_ok   <= bus.lookup_valid && w_lk_cnt_zero;
    end
  end

  assign bus.lookup_done     = r_done;
  assign bus.lookup_hit      = r_hit;
  assign bus.lookup_miss     = r_miss;
  assign bus.lookup_conflict = r_conflict;
  assign bus.lookup_pre_ok   = r_pre_ok;
  assign bus.open_mask       = r_open;
  assign bus.proto_err       = r_err;

`ifdef BANK_ROW_TRACKER_STATS_EN
  logic [31:0] r_stat_hits, r_stat_misses, r_stat_conflicts;

  // Result counters, advanced while the matching result is presented; wrap naturally
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_stat_hits      <= '0;
      r_stat_misses    <= '0;
      r_stat_conflicts <= '0;
    end else begin
      if (r_hit)      r_stat_hits      <= r_stat_hits + 32'd1;
      if (r_miss)     r_stat_misses    <= r_stat_misses + 32'd1;
      if (r_conflict) r_stat_conflicts <= r_stat_conflicts + 32'd1;
    end
  end

  assign bus.stat_hits      = r_stat_hits;
  assign bus.stat_misses    = r_stat_misses;
  assign bus.stat_conflicts = r_stat_conflicts;
`endif

endmodule

// File: tb/tb_bank_row_tracker.sv
// Randomized + directed bench for bank_row_tracker with a queue-based scoreboard.
// The reference model tracks ACT issue cycles instead of countdowns.
`timescale 1ns/1ps
module tb_bank_row_tracker;
  localparam int BGB = 2;
  localparam int BB  = 2;
  localparam int RB  = 16;
  localparam int TR  = 32;
  localparam int NB  = 16;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  bank_row_tracker_if #(.BANK_GROUP_BITS(BGB), .BANK_BITS(BB), .ROW_BITS(RB)) bus_if ();

  bank_row_tracker #(.BANK_GROUP_BITS(BGB), .BANK_BITS(BB), .ROW_BITS(RB), .T_RAS(TR)) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus_if)
  );

  typedef struct packed {
    logic hit;
    logic miss;
    logic conflict;
    logic pre_ok;
  } res_t;

  res_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: open flag, row, and cycle of the last ACT per bank
  bit          m_open [NB];
  logic [RB-1:0] m_row [NB];
  int          m_act  [NB];
  bit          m_err;
  int          cyc;
  int          m_hits, m_misses, m_confs;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [NB-1:0] model_mask();
    logic [NB-1:0] m;
    m = '0;
    for (int i = 0; i < NB; i++) m[i] = m_open[i];
    return m;
  endfunction

  // tRAS satisfied when more than T_RAS cycles separate the ACT cycle from now
  function automatic bit tras_met(input int idx);
    return (cyc - m_act[idx]) > TR;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      m_open[i] = 1'b0;
      m_row[i]  = '0;
      m_act[i]  = -100000;
    end
    m_err = 1'b0;
    cyc = 0;
    m_hits = 0; m_misses = 0; m_confs = 0;
    exp_q.delete();
  endtask

  task automatic clear_inputs();
    bus_if.lookup_valid = 1'b0; bus_if.lookup_bg = '0; bus_if.lookup_bank = '0; bus_if.lookup_row = '0;
    bus_if.cmd_valid = 1'b0; bus_if.cmd_type = 2'b11; bus_if.cmd_bg = '0; bus_if.cmd_bank = '0; bus_if.cmd_row = '0;
  endtask

  // Scoreboard monitor: pops one expectation per presented result
  always @(negedge CLK) begin
    res_t e;
    if (nRST) begin
      if (bus_if.lookup_done === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got lookup_done=1 expected no result");
        end else begin
          e = exp_q.pop_front();
          chk("lookup_hit",      bus_if.lookup_hit,      e.hit);
          chk("lookup_miss",     bus_if.lookup_miss,     e.miss);
          chk("lookup_conflict", bus_if.lookup_conflict, e.conflict);
          chk("lookup_pre_ok",   bus_if.lookup_pre_ok,   e.pre_ok);
        end
      end else begin
        chk("idle_result", {bus_if.lookup_done, bus_if.lookup_hit, bus_if.lookup_miss,
                            bus_if.lookup_conflict, bus_if.lookup_pre_ok}, 64'd0);
      end
    end
  end

  // One clock of stimulus; entered and left 1ns after a rising edge
  task automatic step(input bit lv, input logic [3:0] lidx, input logic [RB-1:0] lrow,
                      input bit cv, input logic [1:0] ct, input logic [3:0] cidx,
                      input logic [RB-1:0] crow);
    res_t e;
    bus_if.lookup_valid = lv; bus_if.lookup_bg = lidx[3:2]; bus_if.lookup_bank = lidx[1:0];
    bus_if.lookup_row = lrow;
    bus_if.cmd_valid = cv; bus_if.cmd_type = ct; bus_if.cmd_bg = cidx[3:2]; bus_if.cmd_bank = cidx[1:0];
    bus_if.cmd_row = crow;
    if (lv) begin
      e.hit      = m_open[lidx] && (m_row[lidx] == lrow);
      e.conflict = m_open[lidx] && (m_row[lidx] != lrow);
      e.miss     = !m_open[lidx];
      e.pre_ok   = tras_met(lidx);
      exp_q.push_back(e);
      if (e.hit) m_hits++;
      if (e.miss) m_misses++;
      if (e.conflict) m_confs++;
    end
    if (cv) begin
      case (ct)
        2'b00: begin
          if (m_open[cidx]) m_err = 1'b1;
          m_open[cidx] = 1'b1; m_row[cidx] = crow; m_act[cidx] = cyc;
        end
        2'b01: if (m_open[cidx]) begin
          if (!tras_met(cidx)) m_err = 1'b1;
          m_open[cidx] = 1'b0;
        end
        2'b10: for (int i = 0; i < NB; i++) begin
          if (m_open[i]) begin
            if (!tras_met(i)) m_err = 1'b1;
            m_open[i] = 1'b0;
          end
        end
        default: ;
      endcase
    end
    @(posedge CLK); #1;
    cyc++;
    clear_inputs();
    chk("open_mask", bus_if.open_mask, model_mask());
    chk("proto_err", bus_if.proto_err, m_err);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 4'd0, '0, 0, 2'b11, 4'd0, '0);
  endtask

  task automatic act(input logic [3:0] idx, input logic [RB-1:0] row);
    step(0, 4'd0, '0, 1, 2'b00, idx, row);
  endtask

  task automatic look(input logic [3:0] idx, input logic [RB-1:0] row);
    step(1, idx, row, 0, 2'b11, 4'd0, '0);
  endtask

  // Asynchronous reset between edges: outputs must drop without a clock
  task automatic do_reset();
    #2;
    nRST = 1'b0;
    #1;
    chk("rst_results", {bus_if.lookup_done, bus_if.lookup_hit, bus_if.lookup_miss,
                        bus_if.lookup_conflict, bus_if.lookup_pre_ok}, 64'd0);
    chk("rst_open_mask", bus_if.open_mask, 64'd0);
    chk("rst_proto_err", bus_if.proto_err, 64'd0);
`ifdef BANK_ROW_TRACKER_STATS_EN
    chk("rst_stats", {bus_if.stat_hits, bus_if.stat_misses[15:0], bus_if.stat_conflicts[15:0]}, 64'd0);
`endif
    model_reset();
    clear_inputs();
    @(posedge CLK); #2;
    nRST = 1'b1;
    @(posedge CLK); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [RB-1:0] rows [4];
    rows[0] = 16'h00AA; rows[1] = 16'h00BB; rows[2] = 16'h1234; rows[3] = 16'hFFFF;
    clear_inputs();
    model_reset();
    @(posedge CLK); #1;
    chk("rst_open_mask_init", bus_if.open_mask, 64'd0);
    chk("rst_proto_err_init", bus_if.proto_err, 64'd0);
    #2 nRST = 1'b1;
    @(posedge CLK); #1;

    // Fresh table: bg=1 bank=2 -> idx 6 misses, PRE legal
    look(4'd6, 16'h00AA);
    act(4'd6, 16'h00AA);
    look(4'd6, 16'h00AA);
    chk("open_bit6", bus_if.open_mask[6], 1'b1);
    look(4'd6, 16'h00BB);
    idle(1);

    // PRE one cycle too early
    do_reset();
    act(4'd6, 16'h0042);
    idle(TR - 1);
    step(0, 4'd0, '0, 1, 2'b01, 4'd6, '0);
    chk("pre_early_err", bus_if.proto_err, 1'b1);
    chk("pre_early_closed", bus_if.open_mask[6], 1'b0);

    // PRE exactly when tRAS has run out
    do_reset();
    act(4'd6, 16'h0042);
    idle(TR);
    step(0, 4'd0, '0, 1, 2'b01, 4'd6, '0);
    chk("pre_ontime_err", bus_if.proto_err, 1'b0);
    chk("pre_ontime_mask", bus_if.open_mask, 64'd0);

    // Same-cycle ACT is invisible to the lookup
    step(1, 4'd3, 16'h0005, 1, 2'b00, 4'd3, 16'h0005);
    look(4'd3, 16'h0005);
    idle(1);

    // PREA after tRAS on several banks, then double ACT
    do_reset();
    act(4'd0, 16'h0001);
    act(4'd5, 16'h0002);
    act(4'd15, 16'h0003);
    idle(TR);
    step(0, 4'd0, '0, 1, 2'b10, 4'd0, '0);
    chk("prea_mask", bus_if.open_mask, 64'd0);
    chk("prea_err", bus_if.proto_err, 1'b0);
    act(4'd0, 16'h0007);
    act(4'd0, 16'h0008);
    chk("double_act_err", bus_if.proto_err, 1'b1);

    // 3 hits, 2 misses, 1 conflict
    do_reset();
    act(4'd1, 16'h0100);
    act(4'd2, 16'h0200);
    look(4'd1, 16'h0100);
    look(4'd1, 16'h0100);
    look(4'd2, 16'h0200);
    look(4'd1, 16'h0999);
    look(4'd4, 16'h0100);
    look(4'd5, 16'h0100);
    idle(2);
`ifdef BANK_ROW_TRACKER_STATS_EN
    chk("stat_hits_dir", bus_if.stat_hits, 32'd3);
    chk("stat_misses_dir", bus_if.stat_misses, 32'd2);
    chk("stat_conflicts_dir", bus_if.stat_conflicts, 32'd1);
`endif

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)), rows[$urandom_range(0, 3)],
           $urandom_range(0, 9) < 2, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
           rows[$urandom_range(0, 3)]);
    end
    idle(2);
`ifdef BANK_ROW_TRACKER_STATS_EN
    chk("stat_hits_rand", bus_if.stat_hits, m_hits);
    chk("stat_misses_rand", bus_if.stat_misses, m_misses);
    chk("stat_conflicts_rand", bus_if.stat_conflicts, m_confs);
`endif

    // Mid-sequence reset with banks open and a result on the outputs
    act(4'd9, 16'h0009);
    look(4'd9, 16'h0009);
    chk("pre_reset_open9", bus_if.open_mask[9], 1'b1);
    do_reset();
    for (int n = 0; n < 100; n++) begin
      step($urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), rows[$urandom_range(0, 1)],
           $urandom_range(0, 9) < 3, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
           rows[$urandom_range(0, 1)]);
    end
    idle(2);
    chk("scoreboard_drained", exp_q.size(), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bank_row_tracker.md
Name: bank_row_tracker

Overview:
- Sits between the address mapper and the DRAM command FSM.
- Keeps a per-bank open-row table, indexed by {BG, bank}, and a per-bank tRAS countdown.
- Classifies each mapped request as row hit, bank closed (miss) or row conflict.
- Reports whether a precharge to the looked-up bank is currently legal.
- Updated by the ACT/PRE/PREA commands the command FSM issues.

Parameters:
- BANK_GROUP_BITS, 2, bank-group index width.
- BANK_BITS, 2, bank-in-group index width; NUM_BANKS = 2**(BANK_GROUP_BITS+BANK_BITS).
- ROW_BITS, 16, row address width.
- T_RAS, 32, ACT-to-PRE minimum in CLK cycles; must be >=1. Counter width is $clog2(T_RAS+1).

Ports:
- CLK  in  1  clock.
- nRST  in  1  asynchronous active-low reset.
- lookup_valid  in  1  classify request this cycle.
- lookup_bg  in  BANK_GROUP_BITS  bank group from mapper.
- lookup_bank  in  BANK_BITS  bank from mapper.
- lookup_row  in  ROW_BITS  row from mapper.
- lookup_done  out  1  result valid, one cycle after lookup_valid.
- lookup_hit  out  1  bank open, same row.
- lookup_miss  out  1  bank closed.
- lookup_conflict  out  1  bank open, different row.
- lookup_pre_ok  out  1  tRAS elapsed for the looked-up bank.
- cmd_valid  in  1  command issued this cycle.
- cmd_type  in  2  00 ACT, 01 PRE, 10 PREA, 11 other (ignored).
- cmd_bg  in  BANK_GROUP_BITS  command bank group.
- cmd_bank  in  BANK_BITS  command bank.
- cmd_row  in  ROW_BITS  row for ACT.
- open_mask  out  NUM_BANKS  bit i = bank i open.
- proto_err  out  1  sticky protocol violation.

Behaviour:
- Bank index idx = {bg, bank}.
- State per bank: open bit, row register, tRAS counter.
- Reset (async, nRST low, at any time including mid-command): all open bits, rows and counters = 0. lookup_done/hit/miss/conflict/pre_ok = 0, open_mask = 0, proto_err = 0.
- Lookup latency is 1 cycle, fully pipelined: one new lookup accepted per cycle, no stall.
  - Cycle N lookup_valid=1 -> cycle N+1 lookup_done=1 with exactly one of hit/miss/conflict =1. lookup_pre_ok = (counter[idx]==0) as of cycle N.
  - lookup_valid=0 -> next cycle lookup_done and all result bits = 0.
- Lookup reads table state as registered at the start of cycle N. A command in the same cycle, even to the same bank, is not visible to that lookup.
- ACT (cmd_valid, type 00):
  - open[idx]<=1, row[idx]<=cmd_row, counter[idx]<=T_RAS.
  - If bank already open: proto_err<=1, table still overwritten.
- PRE (type 01):
  - If open[idx] and counter==0: open[idx]<=0.
  - If open[idx] and counter!=0: proto_err<=1, bank still closed.
  - If bank closed: no-op, no error.
- PREA (type 10):
  - All open bits <=0.
  - proto_err<=1 if any open bank has counter!=0.
- Type 11 or cmd_valid=0: table unchanged.
- Counters:
  - Each nonzero counter decrements by 1 per cycle; saturates at 0.
  - ACT load takes priority over decrement in the same cycle.
  - Counters keep running after PRE; a closed bank's counter is don't-care for legality.
- open_mask is registered and equals the open bits.
- proto_err clears only on reset.

Optional Feature:
- Macro BANK_ROW_TRACKER_STATS_EN.
- With it defined, add outputs stat_hits, stat_misses, stat_conflicts, each 32 bits.
  - Each counter increments on the cycle its lookup_done result asserts.
  - Counters wrap at 2**32-1 -> 0; reset to 0.
- Without it, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then lookup bg=1, bank=2, row=0x00AA -> next cycle lookup_done=1, miss=1, pre_ok=1, open_mask=0.
- ACT bg=1, bank=2, row=0x00AA; next cycle lookup row 0x00AA -> hit=1, pre_ok=0, open_mask[6]=1; lookup row 0x00BB -> conflict=1.
- ACT bank 6, then PRE bank 6 at T_RAS-1 cycles later -> proto_err=1, open_mask[6]=0. Repeat after reset with PRE at exactly T_RAS cycles -> proto_err=0.
- ACT and lookup bank 3 in the same cycle -> lookup reports miss; lookup the following cycle -> hit.
- ACT banks 0, 5, 15; wait T_RAS; PREA -> open_mask=0, proto_err=0. ACT on an already-open bank -> proto_err=1.
- Drop nRST mid-sequence with banks open -> all outputs 0 immediately, without waiting for a CLK edge. With BANK_ROW_TRACKER_STATS_EN: 3 hits, 2 misses, 1 conflict -> stats 3/2/1.
